// File: rtl/sram_pin_responder.sv
// Clock-sampled model of a 16-bit asynchronous SRAM at the device end of the pins.
// Stores committed writes, returns reads after READ_LATENCY clocks and flags protocol abuse.
module sram_pin_responder #(
  parameter int ADDR_WIDTH    = 18,
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH_BITS    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int MIN_WE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] pins_data_in,
  output logic [DATA_WIDTH-1:0] pins_data_out,
  output logic                  pins_data_oe,
  input  logic                  CS,
  input  logic                  OE,
  input  logic                  WE,
  output logic [15:0]           write_count,
  output logic [15:0]           read_count,
  output logic                  contention,
  output logic                  write_error
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  // Wide enough to hold MIN_WE_CYCLES; saturates above it.
  localparam int WCW   = $clog2(MIN_WE_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_VALID, WRITE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    oe_q;
  logic [WCW-1:0]          we_cnt_q;
  logic [3:0]              lat_cnt_q;
  logic [15:0]             wcnt_q, rcnt_q;
  logic                    cont_q, werr_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic sel, rd, wr, addr_chg, commit;

  assign sel      = !CS;
  assign rd       = sel && !OE && WE;
  assign wr       = sel && !WE;
  assign addr_chg = (address != addr_q);
  assign commit   = !reset && (state_q == WRITE) && !wr && (we_cnt_q >= WCW'(MIN_WE_CYCLES));

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit) mem[addr_q[DEPTH_BITS-1:0]] <= data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      we_cnt_q  <= '0;
      lat_cnt_q <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      cont_q    <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      if (sel && !WE && !OE) cont_q <= 1'b1;
      case (state_q)
        IDLE: begin
          oe_q <= 1'b0;
          if (wr) begin
            state_q  <= WRITE;
            addr_q   <= address;
            data_q   <= pins_data_in;
            we_cnt_q <= WCW'(1);
          end else if (rd) begin
            state_q   <= READ_WAIT;
            addr_q    <= address;
            lat_cnt_q <= 4'd1;
          end
        end
        READ_WAIT: begin
          oe_q <= 1'b0;
          if (wr) begin
            state_q  <= WRITE;
            addr_q   <= address;
            data_q   <= pins_data_in;
            we_cnt_q <= WCW'(1);
          end else if (!rd) begin
            state_q <= IDLE;
          end else if (addr_chg) begin
            addr_q    <= address;
            lat_cnt_q <= 4'd1;
          end else if (lat_cnt_q == 4'(READ_LATENCY)) begin
            state_q <= READ_VALID;
            dout_q  <= mem[addr_q[DEPTH_BITS-1:0]];
            oe_q    <= 1'b1;
            rcnt_q  <= rcnt_q + 16'd1;
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end
        READ_VALID: begin
          if (wr) begin
            state_q  <= WRITE;
            oe_q     <= 1'b0;
            addr_q   <= address;
            data_q   <= pins_data_in;
            we_cnt_q <= WCW'(1);
          end else if (!rd) begin
            state_q <= IDLE;
            oe_q    <= 1'b0;
          end else if (addr_chg) begin
            state_q   <= READ_WAIT;
            oe_q      <= 1'b0;
            addr_q    <= address;
            lat_cnt_q <= 4'd1;
          end
        end
        WRITE: begin
          oe_q <= 1'b0;
          if (wr) begin
            data_q <= pins_data_in;
            if (we_cnt_q != '1) we_cnt_q <= we_cnt_q + 1'b1;
            if (addr_chg) begin
              werr_q <= 1'b1;
              addr_q <= address;
            end
          end else begin
            // Commit itself happens in the array process via 'commit'.
            if (we_cnt_q >= WCW'(MIN_WE_CYCLES)) wcnt_q <= wcnt_q + 16'd1;
            else                                 werr_q <= 1'b1;
            if (rd) begin
              state_q   <= READ_WAIT;
              addr_q    <= address;
              lat_cnt_q <= 4'd1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pins_data_out = dout_q;
  assign pins_data_oe  = oe_q;
  assign write_count   = wcnt_q;
  assign read_count    = rcnt_q;
  assign contention    = cont_q;
  assign write_error   = werr_q;

endmodule

// File: tb/tb_sram_pin_responder.sv
// Self-checking bench: bus-level tasks drive the pins, a word-array model predicts results.
module tb_sram_pin_responder;
  localparam int RL  = 2;
  localparam int MWE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] address;
  logic [15:0] pins_data_in;
  logic [15:0] pins_data_out;
  logic        pins_data_oe;
  logic        CS, OE, WE;
  logic [15:0] write_count, read_count;
  logic        contention, write_error;

  sram_pin_responder #(
    .ADDR_WIDTH(18), .DATA_WIDTH(16), .DEPTH_BITS(8),
    .READ_LATENCY(RL), .MIN_WE_CYCLES(MWE)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .pins_data_in(pins_data_in),
    .pins_data_out(pins_data_out), .pins_data_oe(pins_data_oe),
    .CS(CS), .OE(OE), .WE(WE),
    .write_count(write_count), .read_count(read_count),
    .contention(contention), .write_error(write_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: word store indexed by the low 8 address bits.
  logic [15:0] mem_m [256];
  bit          known_m [256];
  logic [15:0] wc_m, rc_m;
  logic        werr_m, cont_m;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    wc_m = 0; rc_m = 0; werr_m = 0; cont_m = 0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input int ncyc);
    CS = 0; OE = 1; WE = 0; address = a; pins_data_in = d;
    repeat (ncyc) step();
    CS = 1; WE = 1; pins_data_in = 16'h0A0A;
    step();
    if (ncyc >= MWE) begin
      mem_m[a[7:0]] = d; known_m[a[7:0]] = 1; wc_m++;
    end else werr_m = 1;
  endtask

  // first_k: number of edges after RD was presented until oe was first seen high (0 = never).
  task automatic do_read(input logic [17:0] a, output int first_k, output logic [15:0] d);
    CS = 0; OE = 0; WE = 1; address = a; first_k = 0; d = '0;
    for (int k = 1; k <= RL + 2; k++) begin
      step();
      if (pins_data_oe && first_k == 0) begin first_k = k; d = pins_data_out; end
    end
    CS = 1; OE = 1;
    step();
    rc_m++;
  endtask

  task automatic test_reset();
    reset = 1; step(); reset = 0;
    model_reset();
    repeat (10) step();
    n_chk++; if (pins_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %0b exp 0", pins_data_oe); end
    n_chk++; if (pins_data_out !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", pins_data_out); end
    n_chk++; if (write_count !== 16'h0) begin n_fail++; $display("FAIL reset_wc got %0d exp 0", write_count); end
    n_chk++; if (read_count !== 16'h0) begin n_fail++; $display("FAIL reset_rc got %0d exp 0", read_count); end
    n_chk++; if (contention !== 1'b0) begin n_fail++; $display("FAIL reset_cont got %0b exp 0", contention); end
    n_chk++; if (write_error !== 1'b0) begin n_fail++; $display("FAIL reset_werr got %0b exp 0", write_error); end
  endtask

  task automatic test_basic();
    int k; logic [15:0] d;
    do_write(18'h00000, 16'hAAAA, 2);
    pins_data_in = 16'h0A0A;
    do_read(18'h00000, k, d);
    n_chk++; if (k != RL + 1) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", k, RL + 1); end
    n_chk++; if (d !== 16'hAAAA) begin n_fail++; $display("FAIL basic_data got %h exp aaaa", d); end
    n_chk++; if (write_count !== wc_m) begin n_fail++; $display("FAIL basic_wc got %0d exp %0d", write_count, wc_m); end
    n_chk++; if (read_count !== rc_m) begin n_fail++; $display("FAIL basic_rc got %0d exp %0d", read_count, rc_m); end
  endtask

  task automatic test_alias();
    int k; logic [15:0] d;
    do_write(18'h00105, 16'h1234, 2);
    do_read(18'h3FF05, k, d);
    n_chk++; if (d !== 16'h1234) begin n_fail++; $display("FAIL alias_data got %h exp 1234", d); end
  endtask

  task automatic test_addr_change();
    logic [15:0] v5, v6;
    v5 = 16'($urandom); v6 = 16'($urandom);
    do_write(18'h5, v5, 2);
    do_write(18'h6, v6, 2);
    CS = 0; OE = 0; WE = 1; address = 18'h5;
    repeat (RL + 1) step();
    n_chk++; if (pins_data_oe !== 1'b1 || pins_data_out !== v5) begin
      n_fail++; $display("FAIL achg_first got oe=%0b d=%h exp oe=1 d=%h", pins_data_oe, pins_data_out, v5); end
    rc_m++;
    address = 18'h6;
    step();
    n_chk++; if (pins_data_oe !== 1'b0) begin n_fail++; $display("FAIL achg_drop got %0b exp 0", pins_data_oe); end
    step();
    n_chk++; if (pins_data_oe !== 1'b0) begin n_fail++; $display("FAIL achg_wait got %0b exp 0", pins_data_oe); end
    step();
    n_chk++; if (pins_data_oe !== 1'b1 || pins_data_out !== v6) begin
      n_fail++; $display("FAIL achg_second got oe=%0b d=%h exp oe=1 d=%h", pins_data_oe, pins_data_out, v6); end
    rc_m++;
    CS = 1; OE = 1; step();
    n_chk++; if (read_count !== rc_m) begin n_fail++; $display("FAIL achg_rc got %0d exp %0d", read_count, rc_m); end
    n_chk++; if (pins_data_oe !== 1'b0) begin n_fail++; $display("FAIL achg_idle_oe got %0b exp 0", pins_data_oe); end
  endtask

  task automatic test_short_we();
    int k; logic [15:0] d;
    do_write(18'h7, 16'h1111, 2);
    n_chk++; if (write_error !== 1'b0) begin n_fail++; $display("FAIL shortwe_pre got %0b exp 0", write_error); end
    do_write(18'h7, 16'hBEEF, 1);
    n_chk++; if (write_error !== werr_m) begin n_fail++; $display("FAIL shortwe_err got %0b exp %0b", write_error, werr_m); end
    n_chk++; if (write_count !== wc_m) begin n_fail++; $display("FAIL shortwe_wc got %0d exp %0d", write_count, wc_m); end
    do_read(18'h7, k, d);
    n_chk++; if (d !== mem_m[7]) begin n_fail++; $display("FAIL shortwe_data got %h exp %h", d, mem_m[7]); end
  endtask

  task automatic test_contention();
    int k; logic [15:0] d;
    do_write(18'h0A, 16'h7777, 2);
    CS = 0; WE = 0; OE = 0; address = 18'h9; pins_data_in = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (pins_data_oe !== 1'b0) begin n_fail++; $display("FAIL cont_oe cyc %0d got %0b exp 0", i, pins_data_oe); end
    end
    cont_m = 1;
    n_chk++; if (contention !== cont_m) begin n_fail++; $display("FAIL cont_flag got %0b exp 1", contention); end
    CS = 1; WE = 1; OE = 1; step();
    mem_m[9] = 16'h5555; known_m[9] = 1; wc_m++;
    do_read(18'h9, k, d);
    n_chk++; if (d !== 16'h5555) begin n_fail++; $display("FAIL cont_data got %h exp 5555", d); end
    // Reset in the middle of a write pulse must drop the write.
    CS = 0; WE = 0; OE = 1; address = 18'h0A; pins_data_in = 16'h9999;
    repeat (2) step();
    reset = 1; step();
    reset = 0; CS = 1; WE = 1; step();
    model_reset();
    n_chk++; if (contention !== 1'b0 || write_error !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags got c=%0b w=%0b exp 0 0", contention, write_error); end
    n_chk++; if (write_count !== 16'h0 || read_count !== 16'h0) begin
      n_fail++; $display("FAIL rst_counts got wc=%0d rc=%0d exp 0 0", write_count, read_count); end
    do_read(18'h0A, k, d);
    n_chk++; if (d !== 16'h7777) begin n_fail++; $display("FAIL rst_nocommit got %h exp 7777", d); end
  endtask

  task automatic test_write_addr_change();
    int k; logic [15:0] d;
    CS = 0; WE = 0; OE = 1; address = 18'h10; pins_data_in = 16'hA1A1;
    step();
    address = 18'h11; pins_data_in = 16'hB2B2;
    step();
    CS = 1; WE = 1; step();
    werr_m = 1; mem_m[8'h11] = 16'hB2B2; known_m[8'h11] = 1; wc_m++;
    n_chk++; if (write_error !== 1'b1) begin n_fail++; $display("FAIL wachg_err got %0b exp 1", write_error); end
    n_chk++; if (write_count !== wc_m) begin n_fail++; $display("FAIL wachg_wc got %0d exp %0d", write_count, wc_m); end
    do_read(18'h11, k, d);
    n_chk++; if (d !== 16'hB2B2) begin n_fail++; $display("FAIL wachg_data got %h exp b2b2", d); end
  endtask

  task automatic test_back_to_back();
    int k; logic [15:0] d, v;
    v = 16'($urandom);
    CS = 0; WE = 0; OE = 1; address = 18'h20; pins_data_in = v;
    repeat (2) step();
    // WE rises with OE already low: the same edge commits and starts the read.
    WE = 1; OE = 0; k = 0; d = '0;
    for (int i = 1; i <= RL + 2; i++) begin
      step();
      if (pins_data_oe && k == 0) begin k = i; d = pins_data_out; end
    end
    CS = 1; OE = 1; step();
    mem_m[8'h20] = v; known_m[8'h20] = 1; wc_m++; rc_m++;
    n_chk++; if (k != RL + 1) begin n_fail++; $display("FAIL b2b_latency got %0d exp %0d", k, RL + 1); end
    n_chk++; if (d !== v) begin n_fail++; $display("FAIL b2b_data got %h exp %h", d, v); end
  endtask

  task automatic test_random();
    int k; logic [15:0] d, v; logic [17:0] a; int n;
    for (int i = 0; i < 60; i++) begin
      a = {10'($urandom_range(0, 1023)), 8'($urandom_range(0, 15))};
      if ($urandom_range(0, 1) == 1) begin
        v = 16'($urandom); n = $urandom_range(1, 3);
        do_write(a, v, n);
      end else begin
        do_read(a, k, d);
        n_chk++; if (k != RL + 1) begin n_fail++; $display("FAIL rnd_latency a=%h got %0d exp %0d", a, k, RL + 1); end
        if (known_m[a[7:0]]) begin
          n_chk++; if (d !== mem_m[a[7:0]]) begin n_fail++; $display("FAIL rnd_data a=%h got %h exp %h", a, d, mem_m[a[7:0]]); end
        end
      end
    end
    n_chk++; if (write_count !== wc_m) begin n_fail++; $display("FAIL rnd_wc got %0d exp %0d", write_count, wc_m); end
    n_chk++; if (read_count !== rc_m) begin n_fail++; $display("FAIL rnd_rc got %0d exp %0d", read_count, rc_m); end
    n_chk++; if (write_error !== werr_m) begin n_fail++; $display("FAIL rnd_werr got %0b exp %0b", write_error, werr_m); end
    n_chk++; if (contention !== cont_m) begin n_fail++; $display("FAIL rnd_cont got %0b exp %0b", contention, cont_m); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem_m[i] = '0; known_m[i] = 0; end
    reset = 1; CS = 1; OE = 1; WE = 1; address = '0; pins_data_in = '0;
    model_reset();
    step();
    test_reset();
    test_basic();
    test_alias();
    test_addr_change();
    test_short_we();
    test_contention();
    test_write_addr_change();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
